// File: rtl/spi_frame_shifter.sv
// Serialises a frame of WORD_W-bit words onto MOSI (SPI mode 0, MSB first) while driving an
// external spi_clk divider, then strobes the LED-driver latch once the whole frame is out.
module spi_frame_shifter #(
  parameter int WORD_W          = 8,
  parameter int WORDS_PER_FRAME = 48,
  parameter int LATCH_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              spi_clk_in,
  input  logic              spi_active_in,
  output logic              spi_start,
  output logic              spi_div_rst,
  output logic              mosi,
  output logic              latch,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int CNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int CYC_W = $clog2(LATCH_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_STOP, S_LATCH, S_ABORT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              buf_full_q, buf_full_d;
  logic              mosi_q, mosi_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              underrun_q, underrun_d;
  logic              aborted_q, aborted_d;
  logic              rise, fall, accept, frame_open;
  logic              active_unused;

  // The divider's active flag is informational only; edges are taken from spi_clk itself.
  assign active_unused = spi_active_in;

  assign rise       = sync_q[1] & ~sync_q[2];
  assign fall       = ~sync_q[1] & sync_q[2];
  assign frame_open = accept_cnt_q < CNT_W'(WORDS_PER_FRAME);

  always_comb begin
    s_ready = 1'b0;
    if (rst) begin
      if (state_q == S_ABORT) s_ready = frame_open;
      else s_ready = frame_open & ~buf_full_q & (state_q != S_LATCH) & (state_q != S_DONE);
    end
  end

  assign accept = s_valid & s_ready;

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], spi_clk_in};
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    sh_d         = sh_q;
    mosi_d       = mosi_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    accept_cnt_d = accept_cnt_q;
    cyc_d        = '0;
    underrun_d   = underrun_q;
    aborted_d    = aborted_q;

    // Words accepted while aborting are counted but thrown away.
    if (accept) begin
      accept_cnt_d = accept_cnt_q + 1'b1;
      if (state_q != S_ABORT) begin
        buf_d      = s_data;
        buf_full_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          sh_d       = buf_q;
          buf_full_d = 1'b0;
          mosi_d     = buf_q[WORD_W-1];
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        underrun_d = 1'b0;
        aborted_d  = 1'b0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (fall) begin
          if (bit_cnt_q < BIT_W'(WORD_W)) begin
            sh_d   = sh_q << 1;
            mosi_d = sh_q[WORD_W-2];
          end else if (word_cnt_q == CNT_W'(WORDS_PER_FRAME - 1)) begin
            mosi_d  = 1'b0;
            state_d = S_STOP;
          end else if (buf_full_q) begin
            sh_d       = buf_q;
            buf_full_d = 1'b0;
            mosi_d     = buf_q[WORD_W-1];
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            underrun_d = 1'b1;
            aborted_d  = 1'b1;
            mosi_d     = 1'b0;
            state_d    = S_ABORT;
          end
        end
      end
      S_STOP: begin
        mosi_d = 1'b0;
        cyc_d  = cyc_q + 1'b1;
        if (cyc_q == CYC_W'(1)) begin
          cyc_d   = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_W'(LATCH_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_DONE;
        end
      end
      S_ABORT: begin
        // Hold at least two cycles, then wait for the rest of the frame to be flushed.
        mosi_d = 1'b0;
        cyc_d  = (cyc_q == CYC_W'(1)) ? cyc_q : cyc_q + 1'b1;
        if (cyc_q == CYC_W'(1) && !frame_open) begin
          cyc_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        accept_cnt_d = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      buf_full_q   <= 1'b0;
      mosi_q       <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      accept_cnt_q <= '0;
      cyc_q        <= '0;
      underrun_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      buf_full_q   <= buf_full_d;
      mosi_q       <= mosi_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      cyc_q        <= cyc_d;
      underrun_q   <= underrun_d;
      aborted_q    <= aborted_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    sh_q  <= sh_d;
  end

  assign spi_start   = (state_q == S_START);
  assign spi_div_rst = (state_q != S_START) && (state_q != S_SHIFT);
  assign mosi        = mosi_q;
  assign latch       = (state_q == S_LATCH);
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE) && !aborted_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: a divider model (half period 4 clk, as for clk_div=7) feeds spi_clk
// back, and each frame is expected to appear on MOSI as its two words concatenated MSB first.
module tb_spi_frame_shifter;
  localparam int WORD_W = 8;
  localparam int WPF    = 2;
  localparam int LATCH_CYCLES = 4;
  localparam int HALF   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       spi_clk_in;
  logic       spi_active_in;
  logic       spi_start, spi_div_rst, mosi, latch, busy, frame_done, underrun;

  logic       div_clk = 1'b0;
  logic       div_act = 1'b0;
  int         div_cnt = 0;
  logic       ext_en, ext_clk;

  always #5 clk = ~clk;

  assign spi_clk_in    = ext_en ? ext_clk : div_clk;
  assign spi_active_in = div_act;

  spi_frame_shifter #(.WORD_W(WORD_W), .WORDS_PER_FRAME(WPF), .LATCH_CYCLES(LATCH_CYCLES)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .spi_clk_in(spi_clk_in), .spi_active_in(spi_active_in), .spi_start(spi_start),
    .spi_div_rst(spi_div_rst), .mosi(mosi), .latch(latch), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  // Divider model: first rise right after start, then a toggle every HALF cycles.
  always @(posedge clk) begin
    if (spi_div_rst !== 1'b0) begin
      div_clk <= 1'b0; div_cnt <= 0; div_act <= 1'b0;
    end else if (spi_start === 1'b1) begin
      div_clk <= 1'b1; div_cnt <= 0; div_act <= 1'b1;
    end else if (div_act) begin
      if (div_cnt == HALF - 1) begin
        div_cnt <= 0; div_clk <= ~div_clk;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [7:0]  tx_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_cur = '0;
  logic [15:0] cap = '0;
  int          rise_idx = 0, latch_cyc = 0, fd_cnt = 0, start_cnt = 0, hs_cnt = 0;
  logic        prev_spi = 1'b0;
  logic        hs_s;

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1);
    tx_q.push_back(w0);
    tx_q.push_back(w1);
    exp_q.push_back({w0, w1});
  endtask

  initial begin : feeder
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      hs_s = s_valid && s_ready && (rst === 1'b1);
      @(posedge clk);
      #1;
      if (hs_s) begin
        hs_cnt++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      if (tx_q.size() > 0) begin
        s_valid = 1'b1; s_data = tx_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (spi_start === 1'b1) begin
          start_cnt++;
          rise_idx = 0;
          cap = '0;
          check("exp_frame_queued", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        end
        if (!ext_en && spi_clk_in && !prev_spi) begin
          if (rise_idx < 16) check($sformatf("mosi_bit%0d", rise_idx), mosi, exp_cur[15-rise_idx]);
          else check("rise_count_le16", rise_idx + 1, 16);
          cap = {cap[14:0], mosi};
          rise_idx++;
        end
        if (latch === 1'b1) latch_cyc++;
        if (frame_done === 1'b1) fd_cnt++;
        if (busy === 1'b0)
          check("idle_quiet", {27'd0, mosi, latch, spi_start, frame_done, spi_div_rst}, 32'd1);
      end
      prev_spi = spi_clk_in;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lc0, fd0, hs0, st0, n;
    rst = 1'b0; ext_en = 1'b0; ext_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_spi_div_rst", spi_div_rst, 1);
    check("rst_mosi", mosi, 0);
    check("rst_latch", latch, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_spi_start", spi_start, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Normal frame 0xA5, 0x3C
    lc0 = latch_cyc; fd0 = fd_cnt;
    send_frame(8'hA5, 8'h3C);
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
    check("t1_completed", busy, 0);
    check("t1_rises", rise_idx, 16);
    check("t1_frame_bits", cap, 16'hA53C);
    check("t1_latch_cycles", latch_cyc - lc0, 4);
    check("t1_frame_done", fd_cnt - fd0, 1);
    check("t1_underrun", underrun, 0);
    check("t1_div_rst", spi_div_rst, 1);

    // Second word late -> underrun and abort
    lc0 = latch_cyc; fd0 = fd_cnt; st0 = start_cnt;
    tx_q.push_back(8'hA5);
    exp_q.push_back(16'hA55A);
    for (int i = 0; i < 300 && !(start_cnt > st0 && rise_idx == 8 && spi_clk_in == 1'b0); i++)
      @(negedge clk);
    n = 0;
    while (spi_div_rst !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("t2_abort_latency_le3", n <= 3, 1);
    check("t2_underrun_set", underrun, 1);
    tx_q.push_back(8'h5A);
    for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
    check("t2_back_to_idle", busy, 0);
    check("t2_word_flushed", tx_q.size(), 0);
    check("t2_no_latch", latch_cyc - lc0, 0);
    check("t2_no_frame_done", fd_cnt - fd0, 0);
    check("t2_rises", rise_idx, 8);
    check("t2_underrun_sticky", underrun, 1);

    // Reset mid-word, then a clean 0xFF frame
    st0 = start_cnt;
    send_frame(8'h81, 8'h7E);
    for (int i = 0; i < 300 && !(start_cnt > st0 && rise_idx >= 3); i++) @(negedge clk);
    check("t3_underrun_cleared", underrun, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t3_s_ready_in_reset", s_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    tx_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("t3_div_rst", spi_div_rst, 1);
    check("t3_mosi", mosi, 0);
    check("t3_busy", busy, 0);
    repeat (4) @(negedge clk);
    lc0 = latch_cyc; fd0 = fd_cnt;
    send_frame(8'hFF, 8'hFF);
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
    check("t3_completed", busy, 0);
    check("t3_rises", rise_idx, 16);
    check("t3_frame_bits", cap, 16'hFFFF);
    check("t3_latch_cycles", latch_cyc - lc0, 4);
    check("t3_frame_done", fd_cnt - fd0, 1);

    // Back-to-back frames, s_valid continuously high
    lc0 = latch_cyc; fd0 = fd_cnt; hs0 = hs_cnt; st0 = start_cnt;
    send_frame(8'hC3, 8'h0F);
    send_frame(8'hF0, 8'h96);
    for (int i = 0; i < 30 && start_cnt == st0; i++) @(negedge clk);
    check("t4_hs_at_start_le2", (hs_cnt - hs0) <= 2, 1);
    for (int i = 0; i < 300 && !(start_cnt > st0 && rise_idx >= 12); i++) @(negedge clk);
    check("t4_s_ready_frame_full", s_ready, 0);
    for (int i = 0; i < 400 && frame_done !== 1'b1; i++) @(negedge clk);
    check("t4_f1_done", frame_done, 1);
    check("t4_f1_rises", rise_idx, 16);
    check("t4_f1_bits", cap, 16'hC30F);
    check("t4_f1_accepted", hs_cnt - hs0, 2);
    n = 0;
    while (spi_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("t4_restart_gap_le4", n <= 4, 1);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
    check("t4_completed", busy, 0);
    check("t4_f2_rises", rise_idx, 16);
    check("t4_f2_bits", cap, 16'hF096);
    check("t4_accepted_total", hs_cnt - hs0, 4);
    check("t4_frame_dones", fd_cnt - fd0, 2);
    check("t4_latch_cycles", latch_cyc - lc0, 8);

    // Idle with spi_clk toggling externally
    st0 = start_cnt;
    ext_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (i % 3 == 0) ext_clk = ~ext_clk;
    end
    @(negedge clk);
    check("t5_no_start", start_cnt - st0, 0);
    check("t5_busy", busy, 0);
    check("t5_mosi", mosi, 0);
    ext_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
